// File: rtl/video_timing_if.sv
// Pixel-timing bundle between the sync generator (master) and its consumers (slave).
// Positions are W bits wide; every output is qualified by the pix_ce driven by the consumer.
interface video_timing_if #(
  parameter int W = 11
);
  logic         pix_ce;
  logic [W-1:0] xpos;
  logic [W-1:0] ypos;
  logic         hsync;
  logic         vsync;
  logic         disp_active;
  logic         line_start;
  logic         frame_start;

  modport master (
    input  pix_ce,
    output xpos, ypos, hsync, vsync, disp_active, line_start, frame_start
  );

  modport slave (
    output pix_ce,
    input  xpos, ypos, hsync, vsync, disp_active, line_start, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Single-clock video sync generator: x/y raster counters advanced by pix_ce, decoded
// and pushed through a DELAY+1 stage register pipeline so sync lines up with downstream pixels.
module video_timing_gen #(
  parameter int H_ACT      = 800,
  parameter int H_FP_END   = 856,
  parameter int H_SYNC_END = 976,
  parameter int H_TOTAL    = 1040,
  parameter int V_ACT      = 600,
  parameter int V_FP_END   = 637,
  parameter int V_SYNC_END = 643,
  parameter int V_TOTAL    = 666,
  parameter int H_POL      = 1,
  parameter int V_POL      = 1,
  parameter int W          = 11,
  parameter int DELAY      = 0
) (
  input  logic           clock,
  input  logic           reset,
  video_timing_if.master vt
);

  if (!(H_ACT < H_FP_END && H_FP_END < H_SYNC_END && H_SYNC_END <= H_TOTAL &&
        V_ACT < V_FP_END && V_FP_END < V_SYNC_END && V_SYNC_END <= V_TOTAL &&
        DELAY >= 0 && DELAY <= 7 && W < 31 &&
        (1 << W) >= H_TOTAL && (1 << W) >= V_TOTAL)) begin : g_param_check
    $error("video_timing_gen: illegal timing parameters");
  end

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         act;
    logic         hs;
    logic         vs;
    logic         ls;
    logic         fs;
  } stage_t;

  // hs/vs are stored as raw "in sync window" flags, so all-zero is the inactive reset state.
  localparam stage_t STAGE_RST = '0;

  localparam logic [W-1:0] H_LAST = W'(H_TOTAL - 1);
  localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);

  // Decode compares run one bit wider so an edge equal to 2^W stays representable.
  localparam logic [W:0] H_ACT_E  = (W+1)'(H_ACT);
  localparam logic [W:0] H_FP_E   = (W+1)'(H_FP_END);
  localparam logic [W:0] H_SYNC_E = (W+1)'(H_SYNC_END);
  localparam logic [W:0] V_ACT_E  = (W+1)'(V_ACT);
  localparam logic [W:0] V_FP_E   = (W+1)'(V_FP_END);
  localparam logic [W:0] V_SYNC_E = (W+1)'(V_SYNC_END);

  logic [W-1:0] xc_q, xc_d;
  logic [W-1:0] yc_q, yc_d;
  stage_t       stage_q [DELAY+1];
  stage_t       stage_d [DELAY+1];
  stage_t       dec;
  stage_t       out_s;

  logic [W:0] xe;
  logic [W:0] ye;
  assign xe = {1'b0, xc_q};
  assign ye = {1'b0, yc_q};

  always_comb begin
    dec.x   = xc_q;
    dec.y   = yc_q;
    dec.act = (xe < H_ACT_E) && (ye < V_ACT_E);
    dec.hs  = (xe >= H_FP_E) && (xe < H_SYNC_E);
    dec.vs  = (ye >= V_FP_E) && (ye < V_SYNC_E);
    dec.ls  = (xc_q == '0);
    dec.fs  = (xc_q == '0) && (yc_q == '0);
  end

  always_comb begin
    // NOTE: every variable gets a hold default up front so no path leaves it unassigned (no latch).
    xc_d    = xc_q;
    yc_d    = yc_q;
    stage_d = stage_q;
    if (vt.pix_ce) begin
      if (xc_q == H_LAST) begin
        xc_d = '0;
        yc_d = (yc_q == V_LAST) ? '0 : yc_q + W'(1);
      end else begin
        xc_d = xc_q + W'(1);
      end
      stage_d[0] = dec;
      for (int i = 1; i <= DELAY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xc_q <= '0;
      yc_q <= '0;
      // NOTE: the pipeline is a small register array, not RAM, so every stage is reset to keep
      // syncs inactive until real positions have propagated through.
      for (int i = 0; i <= DELAY; i++) begin
        stage_q[i] <= STAGE_RST;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all stages shift on the same edge.
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      stage_q <= stage_d;
    end
  end

  assign out_s          = stage_q[DELAY];
  assign vt.xpos        = out_s.x;
  assign vt.ypos        = out_s.y;
  assign vt.disp_active = out_s.act;
  assign vt.line_start  = out_s.ls;
  assign vt.frame_start = out_s.fs;
  assign vt.hsync       = (H_POL != 0) ? out_s.hs : ~out_s.hs;
  assign vt.vsync       = (V_POL != 0) ? out_s.vs : ~out_s.vs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default, inverted polarity + DELAY=3, small raster)
// checked each cycle against a position-from-edge-count model plus hand-computed literals.
module tb_video_timing_gen;

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic pix_ce = 1'b0;
  logic chk_on = 1'b0;

  int tests = 0;
  int fails = 0;
  int n     = 0;  // enabled edges since last reset

  always #5 clock = ~clock;

  video_timing_if #(.W(11)) if_def ();
  video_timing_if #(.W(11)) if_pol ();
  video_timing_if #(.W(5))  if_sml ();
  assign if_def.pix_ce = pix_ce;
  assign if_pol.pix_ce = pix_ce;
  assign if_sml.pix_ce = pix_ce;

  video_timing_gen u_def (.clock(clock), .reset(reset), .vt(if_def));

  video_timing_gen #(.H_POL(0), .V_POL(0), .DELAY(3)) u_pol (
    .clock(clock), .reset(reset), .vt(if_pol));

  video_timing_gen #(
    .H_ACT(8), .H_FP_END(10), .H_SYNC_END(13), .H_TOTAL(16),
    .V_ACT(5), .V_FP_END(6),  .V_SYNC_END(8),  .V_TOTAL(9),
    .W(5), .DELAY(1)
  ) u_sml (.clock(clock), .reset(reset), .vt(if_sml));

  always @(posedge clock or posedge reset) begin
    if (reset)       n <= 0;
    else if (pix_ce) n <= n + 1;
  end

  typedef struct {
    int x; int y; int act; int hs; int vs; int ls; int fs;
  } exp_t;

  // Output after n enabled edges: nothing but reset values until the latency has elapsed,
  // then the raster position numbered n-lat in scan order.
  function automatic exp_t model(int cnt, int lat, int ha, int hfe, int hse, int ht,
                                 int va, int vfe, int vse, int vt, int hpol, int vpol);
    exp_t e;
    int   p;
    if (cnt < lat) begin
      e = '{0, 0, 0, 1 - hpol, 1 - vpol, 0, 0};
    end else begin
      p     = cnt - lat;
      e.x   = p % ht;
      e.y   = (p / ht) % vt;
      e.act = (e.x < ha && e.y < va) ? 1 : 0;
      e.hs  = (e.x >= hfe && e.x < hse) ? hpol : 1 - hpol;
      e.vs  = (e.y >= vfe && e.y < vse) ? vpol : 1 - vpol;
      e.ls  = (e.x == 0) ? 1 : 0;
      e.fs  = (e.x == 0 && e.y == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, n=%0d)", name, got, exp, $time, n);
    end
  endtask

  task automatic cmp(string tag, exp_t e, int x, int y, int a, int h, int v, int l, int f);
    check({tag, "_x"},    x, e.x);
    check({tag, "_y"},    y, e.y);
    check({tag, "_act"},  a, e.act);
    check({tag, "_hs"},   h, e.hs);
    check({tag, "_vs"},   v, e.vs);
    check({tag, "_ls"},   l, e.ls);
    check({tag, "_fs"},   f, e.fs);
  endtask

  task automatic lit_def(string tag, int x, int y, int a, int h, int l, int f);
    check({tag, "_def_x"},   int'(if_def.xpos), x);
    check({tag, "_def_y"},   int'(if_def.ypos), y);
    check({tag, "_def_act"}, int'(if_def.disp_active), a);
    check({tag, "_def_hs"},  int'(if_def.hsync), h);
    check({tag, "_def_ls"},  int'(if_def.line_start), l);
    check({tag, "_def_fs"},  int'(if_def.frame_start), f);
  endtask

  // Per-cycle model comparison plus strobe-period monitors, sampled on the falling edge.
  int prev_n  = 0;
  int last_ls = -1;
  int last_fs = -1;
  int vcnt    = 0;

  always @(negedge clock) begin
    if (chk_on) begin
      cmp("def", model(n, 1, 800, 856, 976, 1040, 600, 637, 643, 666, 1, 1),
          int'(if_def.xpos), int'(if_def.ypos), int'(if_def.disp_active), int'(if_def.hsync),
          int'(if_def.vsync), int'(if_def.line_start), int'(if_def.frame_start));
      cmp("pol", model(n, 4, 800, 856, 976, 1040, 600, 637, 643, 666, 0, 0),
          int'(if_pol.xpos), int'(if_pol.ypos), int'(if_pol.disp_active), int'(if_pol.hsync),
          int'(if_pol.vsync), int'(if_pol.line_start), int'(if_pol.frame_start));
      cmp("sml", model(n, 2, 8, 10, 13, 16, 5, 6, 8, 9, 1, 1),
          int'(if_sml.xpos), int'(if_sml.ypos), int'(if_sml.disp_active), int'(if_sml.hsync),
          int'(if_sml.vsync), int'(if_sml.line_start), int'(if_sml.frame_start));
      if (reset) begin
        last_ls = -1;
        last_fs = -1;
        vcnt    = 0;
        prev_n  = 0;
      end else if (n != prev_n) begin
        if (if_def.line_start) begin
          if (last_ls >= 0) check("def_line_period", n - last_ls, 1040);
          last_ls = n;
        end
        if (if_sml.frame_start) begin
          if (last_fs >= 0) begin
            check("sml_frame_period", n - last_fs, 144);
            check("sml_vsync_edges", vcnt, 32);
          end
          last_fs = n;
          vcnt    = 0;
        end
        if (if_sml.vsync) vcnt++;
        prev_n = n;
      end
    end
  end

  initial begin
    #2 reset = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    lit_def("rst", 0, 0, 0, 0, 0, 0);
    check("rst_pol_hs", int'(if_pol.hsync), 1);
    check("rst_pol_vs", int'(if_pol.vsync), 1);
    reset  = 1'b0;
    pix_ce = 1'b1;

    // Continuous pix_ce: literal pins at the horizontal and vertical edges.
    for (int i = 1; i <= 2200; i++) begin
      @(posedge clock);
      #1;
      case (i)
        1: begin
          lit_def("e1", 0, 0, 1, 0, 1, 1);
          check("e1_def_vs", int'(if_def.vsync), 0);
        end
        2:    lit_def("e2", 1, 0, 1, 0, 0, 0);
        3: begin
          check("e3_pol_act", int'(if_pol.disp_active), 0);
          check("e3_pol_hs",  int'(if_pol.hsync), 1);
          check("e3_pol_fs",  int'(if_pol.frame_start), 0);
        end
        4: begin
          check("e4_pol_fs",  int'(if_pol.frame_start), 1);
          check("e4_pol_act", int'(if_pol.disp_active), 1);
          check("e4_pol_vs",  int'(if_pol.vsync), 1);
        end
        12:   check("e12_sml_hs", int'(if_sml.hsync), 1);
        98: begin
          check("e98_sml_y",  int'(if_sml.ypos), 6);
          check("e98_sml_vs", int'(if_sml.vsync), 1);
        end
        130:  check("e130_sml_vs", int'(if_sml.vsync), 0);
        145: begin
          check("e145_sml_x", int'(if_sml.xpos), 15);
          check("e145_sml_y", int'(if_sml.ypos), 8);
        end
        146: begin
          check("e146_sml_y",  int'(if_sml.ypos), 0);
          check("e146_sml_fs", int'(if_sml.frame_start), 1);
        end
        800:  lit_def("e800", 799, 0, 1, 0, 0, 0);
        801:  lit_def("e801", 800, 0, 0, 0, 0, 0);
        856:  lit_def("e856", 855, 0, 0, 0, 0, 0);
        857:  lit_def("e857", 856, 0, 0, 1, 0, 0);
        860:  check("e860_pol_hs", int'(if_pol.hsync), 0);
        976:  lit_def("e976", 975, 0, 0, 1, 0, 0);
        977:  lit_def("e977", 976, 0, 0, 0, 0, 0);
        979:  check("e979_pol_hs", int'(if_pol.hsync), 0);
        980:  check("e980_pol_hs", int'(if_pol.hsync), 1);
        1040: lit_def("e1040", 1039, 0, 0, 0, 0, 0);
        1041: lit_def("e1041", 0, 1, 1, 0, 1, 0);
        default: ;
      endcase
    end

    // Gated pix_ce: alternate enabled and held cycles.
    for (int i = 0; i < 2200; i++) begin
      @(posedge clock);
      #1 pix_ce = ~pix_ce;
    end
    pix_ce = 1'b1;

    // Run to x=500 mid-line, then reset asynchronously.
    for (int k = 0; k < 3000 && ((n - 1) % 1040 != 500); k++) begin
      @(posedge clock);
      #1;
    end
    check("pre_rst_def_x", int'(if_def.xpos), 500);
    reset = 1'b1;
    #1;
    lit_def("mid_rst", 0, 0, 0, 0, 0, 0);
    check("mid_rst_def_vs", int'(if_def.vsync), 0);
    check("mid_rst_pol_hs", int'(if_pol.hsync), 1);
    check("mid_rst_pol_vs", int'(if_pol.vsync), 1);
    check("mid_rst_sml_x",  int'(if_sml.xpos), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 lit_def("post_rst1", 0, 0, 1, 0, 1, 1);
    @(posedge clock);
    #1 lit_def("post_rst2", 1, 0, 1, 0, 0, 0);
    repeat (300) @(posedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
